// File: rtl/oht2bin_pkg.sv
// Shared types and elaboration-time helpers for the pipelined one-hot to binary encoder.
// Register placement: stage s sits after tree level ceil((s+1)*wlog/stages).
package oht2bin_pkg;

    typedef struct packed {
        logic any;
        logic multi;
    } node_flags_t;

    function automatic int unsigned stage_level(input int unsigned s,
                                                input int unsigned stages,
                                                input int unsigned wlog);
        if (stages == 0) return 0;
        return ((s + 1) * wlog + stages - 1) / stages;
    endfunction

    function automatic bit is_reg_level(input int unsigned l,
                                        input int unsigned stages,
                                        input int unsigned wlog);
        for (int unsigned s = 0; s < stages; s++)
            if (stage_level(s, stages, wlog) == l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int unsigned level_stage(input int unsigned l,
                                                input int unsigned stages,
                                                input int unsigned wlog);
        for (int unsigned s = 0; s < stages; s++)
            if (stage_level(s, stages, wlog) == l) return s;
        return 0;
    endfunction

endpackage

// File: rtl/oht2bin_node.sv
// Combinational radix-2 tree node: merges a low and a high child into a node one level up.
module oht2bin_node
  import oht2bin_pkg::*;
#(
  parameter int LVL = 1,
  localparam int CW = (LVL > 1) ? LVL - 1 : 1
) (
  input  node_flags_t     lo_f,
  input  logic [CW-1:0]   lo_b,
  input  node_flags_t     hi_f,
  input  logic [CW-1:0]   hi_b,
  output node_flags_t     f,
  output logic [LVL-1:0]  b
);

  assign f.any   = lo_f.any | hi_f.any;
  assign f.multi = lo_f.multi | hi_f.multi | (lo_f.any & hi_f.any);

  if (LVL == 1) begin : g_first
    // Leaves carry no index bits; their 1-bit index inputs are driven to 0.
    assign b = hi_f.any | lo_b[0] | hi_b[0];
  end else begin : g_upper
    assign b = {hi_f.any, lo_b | hi_b};
  end

endmodule

// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder on a valid/ready stream, with zero and multi-hot flags.
// Registers sit between tree levels; ready ripples combinationally backwards so bubbles collapse.
module oht2bin_pipe
    import oht2bin_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_oht,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH_LOG-1:0] m_bin,
    output logic                 m_zero,
    output logic                 m_multi
);

    localparam int NPAD = 1 << WIDTH_LOG;

    if (STAGES < 1 || STAGES > WIDTH_LOG) begin : g_bad_stages
        $fatal(1, "oht2bin_pipe: STAGES=%0d outside 1..%0d", STAGES, WIDTH_LOG);
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] up_vld;
    logic [STAGES-1:0] rdy;
    logic [NPAD-1:0]   pad;

    always_comb begin
        pad = '0;
        pad[WIDTH-1:0] = s_oht;
    end

    always_comb begin
        up_vld    = '0;
        up_vld[0] = s_vld;
        for (int unsigned s = 1; s < STAGES; s++) up_vld[s] = vld[s-1];
    end

    // Flattened form of rdy[s] = !vld[s] | rdy[s+1], rdy[STAGES] = m_rdy.
    always_comb begin
        rdy = '0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            rdy[s] = m_rdy;
            for (int unsigned k = s; k < STAGES; k++) rdy[s] = rdy[s] | ~vld[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++)
                if (rdy[s]) vld[s] <= up_vld[s];
        end
    end

    for (genvar l = 0; l <= WIDTH_LOG; l++) begin : g_lvl
        localparam int N  = NPAD >> l;
        localparam int BW = (l == 0) ? 1 : l;

        node_flags_t [N-1:0]         f_o;
        logic        [N-1:0][BW-1:0] b_o;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_n
                assign f_o[i] = '{any: pad[i], multi: 1'b0};
            end
            assign b_o = '0;
        end else begin : g_tree
            node_flags_t [N-1:0]         f_c;
            logic        [N-1:0][BW-1:0] b_c;

            for (genvar i = 0; i < N; i++) begin : g_n
                oht2bin_node #(.LVL(l)) u_node (
                    .lo_f (g_lvl[l-1].f_o[2*i]),
                    .lo_b (g_lvl[l-1].b_o[2*i]),
                    .hi_f (g_lvl[l-1].f_o[2*i+1]),
                    .hi_b (g_lvl[l-1].b_o[2*i+1]),
                    .f    (f_c[i]),
                    .b    (b_c[i])
                );
            end

            if (is_reg_level(l, STAGES, WIDTH_LOG)) begin : g_reg
                localparam int unsigned SI = level_stage(l, STAGES, WIDTH_LOG);

                node_flags_t [N-1:0]         f_q;
                logic        [N-1:0][BW-1:0] b_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        f_q <= '0;
                        b_q <= '0;
                    end else if (rdy[SI] && up_vld[SI]) begin
                        f_q <= f_c;
                        b_q <= b_c;
                    end
                end

                assign f_o = f_q;
                assign b_o = b_q;
            end else begin : g_comb
                assign f_o = f_c;
                assign b_o = b_c;
            end
        end
    end

    assign s_rdy   = rdy[0];
    assign m_vld   = vld[STAGES-1];
    assign m_bin   = g_lvl[WIDTH_LOG].b_o[0];
    assign m_multi = g_lvl[WIDTH_LOG].f_o[0].multi;
    // Gated by valid so the reset (all-zero) root reads as "not zero-input".
    assign m_zero  = m_vld & ~g_lvl[WIDTH_LOG].f_o[0].any;

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Directed and randomised checks of oht2bin_pipe across several WIDTH/STAGES configurations.
module tb_oht2bin_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {bin[4:0], zero, multi}; bin is the OR of all set indices
    function automatic logic [6:0] enc_ref(input logic [31:0] v, input int unsigned w);
        logic [4:0]  b = '0;
        int unsigned n = 0;
        for (int unsigned i = 0; i < w; i++)
            if (v[i]) begin
                b = b | 5'(i);
                n++;
            end
        return {b, (n == 0), (n > 1)};
    endfunction

    // A: WIDTH=32 STAGES=1
    logic a_svld, a_srdy, a_mvld, a_mrdy, a_zero, a_multi;
    logic [31:0] a_oht;
    logic [4:0]  a_bin;
    oht2bin_pipe #(.WIDTH(32), .STAGES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .s_vld(a_svld), .s_rdy(a_srdy), .s_oht(a_oht),
        .m_vld(a_mvld), .m_rdy(a_mrdy), .m_bin(a_bin), .m_zero(a_zero), .m_multi(a_multi));

    // B: WIDTH=32 STAGES=5
    logic b_svld, b_srdy, b_mvld, b_mrdy, b_zero, b_multi;
    logic [31:0] b_oht;
    logic [4:0]  b_bin;
    oht2bin_pipe #(.WIDTH(32), .STAGES(5)) u_b (
        .clk(clk), .rst_n(rst_n), .s_vld(b_svld), .s_rdy(b_srdy), .s_oht(b_oht),
        .m_vld(b_mvld), .m_rdy(b_mrdy), .m_bin(b_bin), .m_zero(b_zero), .m_multi(b_multi));

    // C: WIDTH=12 STAGES=2
    logic c_svld, c_srdy, c_mvld, c_mrdy, c_zero, c_multi;
    logic [11:0] c_oht;
    logic [3:0]  c_bin;
    oht2bin_pipe #(.WIDTH(12), .STAGES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .s_vld(c_svld), .s_rdy(c_srdy), .s_oht(c_oht),
        .m_vld(c_mvld), .m_rdy(c_mrdy), .m_bin(c_bin), .m_zero(c_zero), .m_multi(c_multi));

    // D: WIDTH=32 STAGES=3
    logic d_svld, d_srdy, d_mvld, d_mrdy, d_zero, d_multi;
    logic [31:0] d_oht;
    logic [4:0]  d_bin;
    oht2bin_pipe #(.WIDTH(32), .STAGES(3)) u_d (
        .clk(clk), .rst_n(rst_n), .s_vld(d_svld), .s_rdy(d_srdy), .s_oht(d_oht),
        .m_vld(d_mvld), .m_rdy(d_mrdy), .m_bin(d_bin), .m_zero(d_zero), .m_multi(d_multi));

    // E: WIDTH=20 STAGES=3
    logic e_svld, e_srdy, e_mvld, e_mrdy, e_zero, e_multi;
    logic [19:0] e_oht;
    logic [4:0]  e_bin;
    oht2bin_pipe #(.WIDTH(20), .STAGES(3)) u_e (
        .clk(clk), .rst_n(rst_n), .s_vld(e_svld), .s_rdy(e_srdy), .s_oht(e_oht),
        .m_vld(e_mvld), .m_rdy(e_mrdy), .m_bin(e_bin), .m_zero(e_zero), .m_multi(e_multi));

    logic [31:0] a_vec [2] = '{32'h0000_0001, 32'h8000_0000};
    logic [4:0]  a_exp [2] = '{5'd0, 5'd31};
    logic [11:0] c_vec [3] = '{12'h000, 12'h800, 12'h0A0};
    logic [5:0]  c_exp [3] = '{{4'd0, 1'b1, 1'b0}, {4'd11, 1'b0, 1'b0}, {4'd7, 1'b0, 1'b1}};

    logic [6:0]  q [$];
    logic [7:0]  e_prev;
    logic        e_hold;

    initial begin
        int unsigned acc, rx, seen;
        rst_n = 1'b0;
        {a_svld, a_mrdy, b_svld, b_mrdy, c_svld, c_mrdy, d_svld, d_mrdy, e_svld, e_mrdy} = '0;
        a_oht = '0; b_oht = '0; c_oht = '0; d_oht = '0; e_oht = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_a", {a_mvld, a_bin, a_zero, a_multi}, '0);
        chk("rst_b", {b_mvld, b_bin, b_zero, b_multi}, '0);
        chk("rst_d", {d_mvld, d_bin, d_zero, d_multi}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_srdy_a", a_srdy, 1);
        chk("rst_srdy_d", d_srdy, 1);

        // A: one-cycle latency, index 0 and WIDTH-1
        a_mrdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_svld = (c < 2);
            a_oht  = (c < 2) ? a_vec[c] : '0;
            #1;
            if (c == 1 || c == 2)
                chk("A_out", {a_mvld, a_bin, a_zero, a_multi}, {1'b1, a_exp[c-1], 2'b00});
            else
                chk("A_idle", a_mvld, 0);
        end
        a_svld = 1'b0;

        // B: 32 back-to-back, latency 5
        b_mrdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b_svld = (c < 32);
            b_oht  = (c < 32) ? (32'd1 << c) : '0;
            #1;
            if (c < 32) chk("B_srdy", b_srdy, 1);
            if (c < 5) chk("B_lat", b_mvld, 0);
            else if (c < 37) chk("B_out", {b_mvld, b_bin, b_zero, b_multi}, {1'b1, 5'(c - 5), 2'b00});
            else chk("B_idle", b_mvld, 0);
        end
        b_svld = 1'b0;

        // C: zero, top index, multi-hot on a padded width
        c_mrdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            c_svld = (c < 3);
            c_oht  = (c < 3) ? c_vec[c] : '0;
            #1;
            if (c >= 2) chk("C_out", {c_mvld, c_bin, c_zero, c_multi}, {1'b1, c_exp[c-2]});
            else chk("C_lat", c_mvld, 0);
        end
        c_svld = 1'b0;

        // D: backpressure fill, hold, drain
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            d_mrdy = 1'b0;
            d_svld = 1'b1;
            d_oht  = 32'd1 << acc;
            #1;
            if (d_mvld) chk("D_hold", {d_bin, d_zero, d_multi}, '0);
            if (d_srdy) acc++;
        end
        chk("D_acc", acc, 3);
        chk("D_srdy", d_srdy, 0);
        chk("D_mvld", d_mvld, 1);
        rx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            d_svld = 1'b0;
            d_mrdy = 1'b1;
            #1;
            if (d_mvld) begin
                chk("D_drain", d_bin, rx);
                rx++;
            end
        end
        chk("D_rx", rx, 3);

        // E: random stream with scoreboard
        e_hold = 1'b0;
        e_prev = '0;
        for (int c = 0; c < 10000; c++) begin
            logic [19:0] v;
            int unsigned r;
            @(negedge clk);
            if (e_hold) chk("E_stable", {e_mvld, e_bin, e_zero, e_multi}, e_prev);
            r = $urandom_range(0, 9);
            if (r == 0) v = '0;
            else if (r == 1) v = (20'd1 << $urandom_range(0, 19)) | (20'd1 << $urandom_range(0, 19));
            else v = 20'd1 << $urandom_range(0, 19);
            e_mrdy = ($urandom_range(0, 3) != 0);
            e_svld = ($urandom_range(0, 2) != 0);
            e_oht  = v;
            #1;
            if (e_mvld && e_mrdy) begin
                if (q.size() == 0) chk("E_nonempty", 32'(q.size() != 0), 1);
                else chk("E_out", {e_bin, e_zero, e_multi}, q.pop_front());
            end
            if (e_svld && e_srdy) q.push_back(enc_ref({12'd0, e_oht}, 20));
            e_hold = e_mvld & ~e_mrdy;
            e_prev = {e_mvld, e_bin, e_zero, e_multi};
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e_svld = 1'b0;
            e_mrdy = 1'b1;
            #1;
            if (e_mvld) begin
                if (q.size() == 0) chk("E_nonempty", 32'(q.size() != 0), 1);
                else chk("E_out", {e_bin, e_zero, e_multi}, q.pop_front());
            end
        end
        chk("E_left", q.size(), 0);

        // F: asynchronous reset mid-stream
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            d_mrdy = 1'b0;
            d_svld = 1'b1;
            d_oht  = 32'h0000_0020;
        end
        #1;
        chk("F_pre", {d_mvld, d_bin}, {1'b1, 5'd5});
        #1;
        rst_n = 1'b0;
        #1;
        chk("F_rst", {d_mvld, d_bin, d_zero, d_multi}, '0);
        @(negedge clk);
        rst_n  = 1'b1;
        d_svld = 1'b0;
        d_mrdy = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (d_mvld) seen++;
        end
        chk("F_stale", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
